// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: owns the single register-file write port.
// The in-order pipeline writeback has no backpressure, so it always wins the port.
// A multi-cycle MDU result that loses the port waits in a one-entry skid buffer.
// A wait counter raises a stall request when that buffered result has waited MAX_WAIT cycles.
// A pending-destination scoreboard tracks issued MDU ops and reports RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  pipe_we_i,
  input  logic [4:0]            pipe_rd_i,
  input  logic [DATA_WIDTH-1:0] pipe_data_i,
  input  logic                  mdu_valid_i,
  input  logic [4:0]            mdu_rd_i,
  input  logic [DATA_WIDTH-1:0] mdu_data_i,
  output logic                  mdu_ready_o,
  input  logic                  issue_mdu_i,
  input  logic [4:0]            issue_rd_i,
  input  logic [4:0]            adrs1_i,
  input  logic [4:0]            adrs2_i,
  input  logic [4:0]            adrs_rd_i,
  output logic                  hazard_o,
  output logic                  stall_req_o,
  output logic                  write_enable_o,
  output logic [4:0]            wb_address_o,
  output logic [DATA_WIDTH-1:0] write_data_o
);

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  // Write port output register; src_mdu marks a write that came from the MDU
  logic                  we_q, we_d;
  logic [4:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  src_mdu_q, src_mdu_d;

  // One-entry skid buffer for an MDU result that lost arbitration
  logic                  buf_valid_q, buf_valid_d;
  logic [4:0]            buf_rd_q, buf_rd_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;

  // Starvation tracking for the buffered result
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [3:0]            wait_cnt_inc;
  logic                  stall_q, stall_d;

  // Pending-destination scoreboard for issued MDU ops
  logic [31:0]           pending_q, pending_d;

  logic                  pipe_win;
  logic                  mdu_accept;
  logic                  drain;

  assign mdu_ready_o    = !buf_valid_q;
  assign hazard_o       = pending_q[adrs1_i] | pending_q[adrs2_i] | pending_q[adrs_rd_i];
  assign stall_req_o    = stall_q;
  assign write_enable_o = we_q;
  assign wb_address_o   = addr_q;
  assign write_data_o   = data_q;

  assign pipe_win     = pipe_we_i && (pipe_rd_i != 5'd0);
  assign mdu_accept   = mdu_valid_i && mdu_ready_o;
  assign wait_cnt_inc = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;

  // Port arbitration: pipeline first, then the buffered MDU result, then a direct MDU result.
  // An accepted MDU result with rd=0 completes its handshake here and is simply dropped.
  always_comb begin
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    src_mdu_d   = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    drain       = 1'b0;
    if (pipe_win) begin
      we_d   = 1'b1;
      addr_d = pipe_rd_i;
      data_d = pipe_data_i;
      if (mdu_accept && (mdu_rd_i != 5'd0)) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = mdu_rd_i;
        buf_data_d  = mdu_data_i;
      end
    end else if (buf_valid_q) begin
      we_d        = 1'b1;
      addr_d      = buf_rd_q;
      data_d      = buf_data_q;
      src_mdu_d   = 1'b1;
      buf_valid_d = 1'b0;
      drain       = 1'b1;
    end else if (mdu_accept && (mdu_rd_i != 5'd0)) begin
      we_d      = 1'b1;
      addr_d    = mdu_rd_i;
      data_d    = mdu_data_i;
      src_mdu_d = 1'b1;
    end
  end

  // Wait counter and stall request; an active stall is held through the drain cycle
  always_comb begin
    wait_cnt_d = 4'd0;
    stall_d    = 1'b0;
    if (buf_valid_q && !drain) begin
      wait_cnt_d = wait_cnt_inc;
      stall_d    = (wait_cnt_inc >= MaxWaitC);
    end else if (drain) begin
      stall_d = stall_q;
    end
  end

  // Scoreboard: clear when the register file captures an MDU write, then set on issue so set wins
  always_comb begin
    pending_d = pending_q;
    if (we_q && src_mdu_q) begin
      pending_d[addr_q] = 1'b0;
    end
    if (issue_mdu_i && (issue_rd_i != 5'd0)) begin
      pending_d[issue_rd_i] = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      we_q        <= 1'b0;
      addr_q      <= 5'd0;
      data_q      <= '0;
      src_mdu_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= '0;
      wait_cnt_q  <= 4'd0;
      stall_q     <= 1'b0;
      pending_q   <= 32'd0;
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      src_mdu_q   <= src_mdu_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_q     <= stall_d;
      pending_q   <= pending_d;
    end
  end

endmodule
